// File: rtl/inst_uart_loader.sv
// inst_uart_loader: UART (8N1) boot loader that writes a framed program image into instruction RAM.
module inst_uart_loader #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        debug,
    output logic        inst_ram_write_enable,
    output logic [31:0] inst_ram_write_data,
    output logic [15:0] inst_ram_write_address,
    output logic        load_done,
    output logic        load_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, FINISH} state_t;

    logic          rx_s1_q, rx_s2_q;
    rx_state_t     rstate_q, rstate_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          bv_q, bv_d, ferr_q, ferr_d;
    state_t        state_q, state_d;
    logic [7:0]    nhi_q, nhi_d;
    logic [15:0]   rem_q, rem_d, addr_q, addr_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [23:0]   word_q, word_d;
    logic [31:0]   data_q, data_d;
    logic          first_q, first_d, err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rstate_q <= R_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            bv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            state_q  <= IDLE;
            nhi_q    <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            bidx_q   <= '0;
            word_q   <= '0;
            data_q   <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rx_s1_q  <= rx;
            rx_s2_q  <= rx_s1_q;
            rstate_q <= rstate_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            bv_q     <= bv_d;
            ferr_q   <= ferr_d;
            state_q  <= state_d;
            nhi_q    <= nhi_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            bidx_q   <= bidx_d;
            word_q   <= word_d;
            data_q   <= data_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

    // Receiver: start bit re-checked at half bit, then every sample lands at a bit centre.
    always_comb begin
        rstate_d = rstate_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        sh_d     = sh_q;
        bv_d     = 1'b0;
        ferr_d   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                cnt_d = '0;
                if (!rx_s2_q) rstate_d = R_START;
            end
            R_START: if (cnt_q == HALF) begin
                cnt_d    = '0;
                bit_d    = '0;
                rstate_d = rx_s2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {rx_s2_q, sh_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) rstate_d = R_STOP;
            end
            R_STOP: if (cnt_q == FULL) begin
                rstate_d = R_IDLE;
                bv_d     = 1'b1;
                ferr_d   = !rx_s2_q;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Load FSM: address is advanced when a word is committed so the outputs hold between writes.
    always_comb begin
        state_d = state_q;
        nhi_d   = nhi_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        data_d  = data_q;
        first_d = first_q;
        err_d   = err_q;
        if (bv_q && ferr_q && state_q != IDLE) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (bv_q && !ferr_q && sh_q == 8'hA5) begin
                    state_d = CNT_HI;
                    err_d   = 1'b0;
                end
                CNT_HI: if (bv_q) begin
                    nhi_d   = sh_q;
                    state_d = CNT_LO;
                end
                CNT_LO: if (bv_q) begin
                    rem_d   = {nhi_q, sh_q};
                    bidx_d  = '0;
                    first_d = 1'b1;
                    state_d = ({nhi_q, sh_q} == 16'd0) ? FINISH : DATA;
                end
                DATA: if (bv_q) begin
                    word_d = {word_q[15:0], sh_q};
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) begin
                        data_d  = {word_q, sh_q};
                        addr_d  = first_q ? 16'd0 : addr_q + 16'd4;
                        first_d = 1'b0;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? FINISH : DATA;
                end
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign debug                  = state_q inside {CNT_HI, CNT_LO, DATA, WRITE};
    assign inst_ram_write_enable  = state_q == WRITE;
    assign load_done              = state_q == FINISH;
    assign inst_ram_write_data    = data_q;
    assign inst_ram_write_address = addr_q;
    assign load_error             = err_q;
endmodule

// File: tb/tb_inst_uart_loader.sv
// tb_inst_uart_loader: directed bench for the UART instruction loader at four clocks per bit.
module tb_inst_uart_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        debug, we, load_done, load_error;
    logic [31:0] wdata;
    logic [15:0] waddr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;
    int n_rise = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    logic done_dbg = 1'b0;
    logic prev_dbg = 1'b0;
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    logic        wdbg[$];
    int w0, d0, r0;

    inst_uart_loader #(.CLKS_PER_BIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .debug(debug),
        .inst_ram_write_enable(we),
        .inst_ram_write_data(wdata),
        .inst_ram_write_address(waddr),
        .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_dbg <= debug;
        if (debug && !prev_dbg) n_rise <= n_rise + 1;
        if (we) begin
            wa.push_back(waddr);
            wd.push_back(wdata);
            wdbg.push_back(debug);
            last_wr_cyc <= cyc;
        end
        if (load_done) begin
            n_done <= n_done + 1;
            done_cyc <= cyc;
            done_dbg <= debug;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic mark();
        w0 = wa.size();
        d0 = n_done;
        r0 = n_rise;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_debug", debug, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", waddr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Two-word load
        mark();
        send_byte(8'hA5);
        repeat (3) @(negedge clk);
        chk("tw_dbg_rise", debug, 1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        repeat (20) @(negedge clk);
        chk("tw_nwr", wa.size() - w0, 2);
        chk("tw_a0", wa[w0], 16'h0000);
        chk("tw_d0", wd[w0], 32'h12345678);
        chk("tw_a1", wa[w0+1], 16'h0004);
        chk("tw_d1", wd[w0+1], 32'h9ABCDEF0);
        chk("tw_dbg_wr0", wdbg[w0], 1);
        chk("tw_dbg_wr1", wdbg[w0+1], 1);
        chk("tw_ndone", n_done - d0, 1);
        chk("tw_done_lat", done_cyc - last_wr_cyc, 1);
        chk("tw_done_dbg", done_dbg, 0);
        chk("tw_rises", n_rise - r0, 1);
        chk("tw_err", load_error, 0);
        chk("tw_dbg_end", debug, 0);
        chk("tw_hold_a", waddr, 16'h0004);
        chk("tw_hold_d", wdata, 32'h9ABCDEF0);

        // Zero count
        mark();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (20) @(negedge clk);
        chk("zc_nwr", wa.size() - w0, 0);
        chk("zc_ndone", n_done - d0, 1);
        chk("zc_rises", n_rise - r0, 1);
        chk("zc_dbg", debug, 0);

        // Idle junk then one word
        mark();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        repeat (10) @(negedge clk);
        chk("ij_dbg_junk", debug, 0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hDEADBEEF);
        repeat (20) @(negedge clk);
        chk("ij_nwr", wa.size() - w0, 1);
        chk("ij_a0", wa[w0], 16'h0000);
        chk("ij_d0", wd[w0], 32'hDEADBEEF);
        chk("ij_ndone", n_done - d0, 1);

        // Framing error in the second word
        mark();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h11223344);
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        chk("fe_nwr", wa.size() - w0, 1);
        chk("fe_a0", wa[w0], 16'h0000);
        chk("fe_d0", wd[w0], 32'h11223344);
        chk("fe_dbg", debug, 0);
        chk("fe_err", load_error, 1);
        chk("fe_ndone", n_done - d0, 0);
        mark();
        send_byte(8'hA5);
        repeat (3) @(negedge clk);
        chk("fe_err_clr", load_error, 0);
        chk("fe_dbg_again", debug, 1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hCAFEBABE);
        repeat (20) @(negedge clk);
        chk("fe2_a0", wa[w0], 16'h0000);
        chk("fe2_d0", wd[w0], 32'hCAFEBABE);
        chk("fe2_ndone", n_done - d0, 1);

        // Reset in the middle of the second word
        mark();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h05);
        send_word(32'h01020304);
        send_byte(8'h05);
        send_byte(8'h06);
        repeat (5) @(negedge clk);
        chk("rm_dbg_pre", debug, 1);
        #1 reset = 1'b0;
        #1;
        chk("rm_debug", debug, 0);
        chk("rm_we", we, 0);
        chk("rm_addr", waddr, 0);
        chk("rm_data", wdata, 0);
        chk("rm_err", load_error, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("rm_nwr", wa.size() - w0, 1);
        chk("rm_d0", wd[w0], 32'h01020304);
        chk("rm_ndone", n_done - d0, 0);
        mark();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hAABBCCDD);
        repeat (20) @(negedge clk);
        chk("rm2_a0", wa[w0], 16'h0000);
        chk("rm2_d0", wd[w0], 32'hAABBCCDD);

        // Glitch rejection
        mark();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("gl_dbg", debug, 0);
        chk("gl_rises", n_rise - r0, 0);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h0BADF00D);
        repeat (20) @(negedge clk);
        chk("gl_nwr", wa.size() - w0, 1);
        chk("gl_d0", wd[w0], 32'h0BADF00D);
        chk("gl_ndone", n_done - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
